// File: rtl/booth_mult_arbiter_pkg.sv
// Shared definitions for the Booth multiplier arbiter: FSM encodings, datapath widths,
// and the radix-4 Booth partial-product selector.
package booth_mult_arbiter_pkg;

   localparam int OPW = 4;
   localparam int PW  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Radix-4 Booth digit {x[2i+1], x[2i], x[2i-1]} selects 0, +-a or +-2a.
   function automatic logic [PW-1:0] booth_pp(input logic [2:0] grp, input logic [PW-1:0] a_ext);
      logic [PW-1:0] pp;
      pp = '0;
      case (grp)
         3'b001, 3'b010: pp = a_ext;
         3'b011:         pp = a_ext << 1;
         3'b100:         pp = -(a_ext << 1);
         3'b101, 3'b110: pp = -a_ext;
         default:        pp = '0;
      endcase
      return pp;
   endfunction

endpackage

// File: rtl/booth_mult_arbiter_booth.sv
// Combinational 4x4 signed radix-4 Booth multiplier; exact over the full signed range.
module multiplicador_Booth
   import booth_mult_arbiter_pkg::*;
(
   input  logic [OPW-1:0] a,
   input  logic [OPW-1:0] x,
   output logic [PW-1:0]  p
);

   logic [PW-1:0] a_ext;
   logic [PW-1:0] pp0;
   logic [PW-1:0] pp1;

   assign a_ext = {{(PW-OPW){a[OPW-1]}}, a};
   assign pp0   = booth_pp({x[1:0], 1'b0}, a_ext);
   assign pp1   = booth_pp(x[3:1], a_ext);
   assign p     = pp0 + (pp1 << 2);

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end sharing one Booth multiplier among NREQ valid/ready requesters,
// with a single registered response channel and one operation in flight.
module booth_mult_arbiter
   import booth_mult_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [OPW*NREQ-1:0] req_a,
   input  logic [OPW*NREQ-1:0] req_x,
   output logic [NREQ-1:0]     req_ready,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [IDW-1:0]      resp_id,
   output logic [PW-1:0]       resp_p
);

   state_t         state_q;
   state_t         state_d;
   logic [IDW-1:0] rr_q;
   logic [IDW-1:0] rr_next;
   logic [IDW-1:0] grant;
   logic           grant_vld;
   logic [OPW-1:0] a_sel;
   logic [OPW-1:0] x_sel;
   logic [OPW-1:0] a_q;
   logic [OPW-1:0] x_q;
   logic [IDW-1:0] id_q;
   logic [PW-1:0]  prod;
   logic           accept;

   // First valid requester at or after ptr, wrapping at NREQ; MSB flags a hit.
   function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] ptr);
      logic [IDW:0]   res;
      logic [IDW-1:0] idx_b;
      logic           found;
      int             idx;
      res   = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         idx_b = IDW'(idx);
         if (!found && v[idx_b]) begin
            found = 1'b1;
            res   = {1'b1, idx_b};
         end
      end
      return res;
   endfunction

   always_comb begin
      {grant_vld, grant} = rr_pick(req_valid, rr_q);
   end

   always_comb begin
      a_sel = '0;
      x_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant == IDW'(i)) begin
            a_sel = req_a[i*OPW +: OPW];
            x_sel = req_x[i*OPW +: OPW];
         end
      end
   end

   assign rr_next = (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
   assign accept  = (state_q == IDLE) && grant_vld && !rst;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               req_ready[grant] = 1'b1;
               state_d          = MULT;
            end
         end
         MULT:    state_d = RESP;
         RESP:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_q       <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_p     <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (accept) rr_q <= rr_next;
            MULT: begin
               resp_p     <= prod;
               resp_id    <= id_q;
               resp_valid <= 1'b1;
            end
            RESP:    if (resp_ready) resp_valid <= 1'b0;
            default: resp_valid <= 1'b0;
         endcase
      end
   end

   // NOTE: operand holding registers are deliberately not reset; they are only read in MULT, which always follows a capture.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q  <= a_sel;
         x_q  <= x_sel;
         id_q <= grant;
      end
   end

   multiplicador_Booth u_mult (
      .a (a_q),
      .x (x_q),
      .p (prod)
   );

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Self-checking bench: directed signed/arbitration/stall/reset cases plus random traffic
// against a cycle-timed transaction model of the arbiter.
module tb_booth_mult_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [4*NREQ-1:0]   req_a = '0;
   logic [4*NREQ-1:0]   req_x = '0;
   logic [NREQ-1:0]     req_ready;
   logic                resp_valid;
   logic                resp_ready = 1'b0;
   logic [IDW-1:0]      resp_id;
   logic [7:0]          resp_p;

   int total = 0;
   int bad   = 0;

   // Reference model: one transaction in flight, timed by cycles since acceptance.
   bit         in_flight = 1'b0;
   int         age       = 0;
   int         rr_m      = 0;
   int         exp_id    = 0;
   logic [7:0] exp_p     = '0;
   int         grants_q[$];
   logic [7:0] obs_p     = '0;
   int         obs_id    = 0;

   booth_mult_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_x      (req_x),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_p     (resp_p)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
      for (int i = 0; i < NREQ; i++)
         if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
      return -1;
   endfunction

   // One clock: drive inputs after the edge, then compare outputs against the model at the falling edge.
   task automatic step(input logic r, input logic [NREQ-1:0] v, input logic [4*NREQ-1:0] a,
                       input logic [4*NREQ-1:0] x, input logic rr_in);
      logic [NREQ-1:0]  exp_rdy;
      int               g;
      logic signed [3:0] sa;
      logic signed [3:0] sx;
      @(posedge clk);
      #1;
      rst        = r;
      req_valid  = v;
      req_a      = a;
      req_x      = x;
      resp_ready = rr_in;
      @(negedge clk);
      if (r) begin
         check("req_ready_in_rst", 32'(req_ready), 32'd0);
         in_flight = 1'b0;
         rr_m      = 0;
         return;
      end
      if (!in_flight) begin
         exp_rdy = '0;
         check("resp_valid_idle", 32'(resp_valid), 32'd0);
         if (v != '0) begin
            g          = pick(v, rr_m);
            exp_rdy[g] = 1'b1;
            sa         = a[4*g +: 4];
            sx         = x[4*g +: 4];
            exp_p      = 8'(int'(sa) * int'(sx));
            exp_id     = g;
            in_flight  = 1'b1;
            age        = 0;
            rr_m       = (g + 1) % NREQ;
            grants_q.push_back(g);
         end
         check("req_ready", 32'(req_ready), 32'(exp_rdy));
      end else begin
         age++;
         check("req_ready_busy", 32'(req_ready), 32'd0);
         check("resp_valid", 32'(resp_valid), 32'(age >= 2));
         if (age >= 2) begin
            check("resp_id", 32'(resp_id), 32'(exp_id));
            check("resp_p", 32'(resp_p), 32'(exp_p));
            if (rr_in) begin
               in_flight = 1'b0;
               obs_p     = resp_p;
               obs_id    = int'(resp_id);
            end
         end
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && in_flight; k++) step(1'b0, '0, '0, '0, 1'b1);
      check("drain_done", 32'(in_flight), 32'd0);
   endtask

   task automatic xact(input int i, input logic [3:0] a, input logic [3:0] x);
      logic [4*NREQ-1:0] pa;
      logic [4*NREQ-1:0] px;
      pa = '0;
      px = '0;
      pa[4*i +: 4] = a;
      px[4*i +: 4] = x;
      step(1'b0, NREQ'(1) << i, pa, px, 1'b1);
      drain();
   endtask

   task automatic do_reset();
      step(1'b1, '0, '0, '0, 1'b0);
      step(1'b1, '0, '0, '0, 1'b0);
      step(1'b0, '0, '0, '0, 1'b0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_p", 32'(resp_p), 32'd0);
      check("rst_resp_id", 32'(resp_id), 32'd0);
   endtask

   initial begin
      logic [3:0] ta [5] = '{4'h4, 4'hD, 4'hB, 4'h8, 4'h8};
      logic [3:0] tx [5] = '{4'hC, 4'h5, 4'hA, 4'h8, 4'h7};
      logic [7:0] te [5] = '{8'hF0, 8'hF1, 8'h1E, 8'h40, 8'hC8};
      int         exp_g [5] = '{0, 1, 2, 3, 0};
      logic [15:0] pa;
      logic [15:0] px;

      do_reset();

      // Single request on requester 0.
      xact(0, 4'h7, 4'h3);
      check("t1_p", 32'(obs_p), 32'h15);
      check("t1_id", 32'(obs_id), 32'd0);

      // Signed corners through requester 1.
      for (int k = 0; k < 5; k++) begin
         xact(1, ta[k], tx[k]);
         check($sformatf("t2_p%0d", k), 32'(obs_p), 32'(te[k]));
         check($sformatf("t2_id%0d", k), 32'(obs_id), 32'd1);
      end

      // All requesters continuously valid: strict rotation from pointer 0.
      do_reset();
      grants_q.delete();
      pa = 16'h8D57;
      px = 16'h73AE;
      for (int k = 0; k < 40 && grants_q.size() < 5; k++) step(1'b0, 4'hF, pa, px, 1'b1);
      drain();
      check("t3_ngrants", 32'(grants_q.size()), 32'd5);
      for (int k = 0; k < 5 && k < grants_q.size(); k++)
         check($sformatf("t3_grant%0d", k), 32'(grants_q[k]), 32'(exp_g[k]));

      // Consumer stall: five cycles of resp_ready low with requests pending.
      pa = 16'h0600;
      px = 16'h0900;
      step(1'b0, 4'b0100, pa, px, 1'b0);
      step(1'b0, 4'hF, pa, px, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 4'hF, pa, px, 1'b0);
         check("t4_hold_p", 32'(resp_p), 32'hD6);
         check("t4_hold_id", 32'(resp_id), 32'd2);
      end
      step(1'b0, 4'h0, pa, px, 1'b1);
      check("t4_released", 32'(in_flight), 32'd0);
      step(1'b0, 4'h0, pa, px, 1'b1);

      // Reset during MULT.
      xact(2, 4'h5, 4'h3);
      step(1'b0, 4'b0010, 16'h0070, 16'h0050, 1'b1);
      step(1'b1, 4'b0000, '0, '0, 1'b1);
      for (int k = 0; k < 4; k++) step(1'b0, 4'b0000, '0, '0, 1'b1);
      check("t5m_p", 32'(resp_p), 32'd0);
      check("t5m_id", 32'(resp_id), 32'd0);
      grants_q.delete();
      step(1'b0, 4'hF, 16'h1111, 16'h2222, 1'b1);
      drain();
      check("t5m_rr", (grants_q.size() > 0) ? 32'(grants_q[0]) : 32'hFFFF_FFFF, 32'd0);

      // Reset during RESP.
      xact(3, 4'h7, 4'h7);
      step(1'b0, 4'b1000, 16'h6000, 16'h5000, 1'b0);
      step(1'b0, 4'b0000, '0, '0, 1'b0);
      step(1'b0, 4'b0000, '0, '0, 1'b0);
      check("t5r_seen_valid", 32'(resp_valid), 32'd1);
      step(1'b1, 4'b0000, '0, '0, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b0, 4'b0000, '0, '0, 1'b1);
      check("t5r_p", 32'(resp_p), 32'd0);
      check("t5r_id", 32'(resp_id), 32'd0);
      grants_q.delete();
      step(1'b0, 4'hF, 16'h3333, 16'h4444, 1'b1);
      drain();
      check("t5r_rr", (grants_q.size() > 0) ? 32'(grants_q[0]) : 32'hFFFF_FFFF, 32'd0);

      // Random traffic.
      for (int k = 0; k < 3000; k++)
         step(1'b0, NREQ'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 9) < 7));
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
